// File: rtl/float_pkg.sv
// Shared types for the tagged-float argmin path: tag geometry, default tagged word, feeder FSM states.
// Modules that carry a different float width rebuild the tagged word locally from FLOAT_W/TAG_W.
package float_pkg;

  localparam int FLOAT_W = 32;
  localparam int TAG_W   = 4;
  localparam logic [TAG_W-1:0] TAG_MAX = '1;

  typedef struct packed {
    logic [FLOAT_W-1:0] value;
    logic [TAG_W-1:0]   tag;
  } tagged_t;

  typedef enum logic [1:0] {
    EMPTY,
    HELD,
    PAIR
  } feeder_state_e;

endpackage

// File: rtl/float_argmin_feeder_if.sv
// Stream bundle around the feeder: untagged input stream, paired a/b tagged output streams, overflow flag.
// The slave modport is the feeder's view; master is the view of the logic surrounding it.
interface float_argmin_feeder_if #(
  parameter int SIZE = 32
);

  logic [SIZE-1:0] s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;

  logic [SIZE+3:0] m_axis_a_tdata;
  logic            m_axis_a_tvalid;
  logic            m_axis_a_tready;
  logic            m_axis_a_tlast;

  logic [SIZE+3:0] m_axis_b_tdata;
  logic            m_axis_b_tvalid;
  logic            m_axis_b_tready;
  logic            m_axis_b_tlast;

  logic            tag_overflow;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_a_tdata, m_axis_a_tvalid, m_axis_a_tlast,
    input  m_axis_a_tready,
    output m_axis_b_tdata, m_axis_b_tvalid, m_axis_b_tlast,
    input  m_axis_b_tready,
    output tag_overflow
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_a_tdata, m_axis_a_tvalid, m_axis_a_tlast,
    output m_axis_a_tready,
    input  m_axis_b_tdata, m_axis_b_tvalid, m_axis_b_tlast,
    output m_axis_b_tready,
    input  tag_overflow
  );

endinterface

// File: rtl/float_argmin_feeder.sv
// Tags each input float with its packet index and presents elements in a/b pairs, padding odd packets.
// Pair valid 1 cycle after the completing input; input stalls (tready=0) while a pair is outstanding.
module float_argmin_feeder
  import float_pkg::*;
#(
  parameter int SIZE = FLOAT_W
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  float_argmin_feeder_if.slave bus
);

  typedef struct packed {
    logic [SIZE-1:0]  value;
    logic [TAG_W-1:0] tag;
  } word_t;

  feeder_state_e    state;
  word_t            a_word;
  word_t            b_word;
  word_t            in_word;
  logic [TAG_W-1:0] idx;
  logic             pair_last;
  logic             a_done;
  logic             b_done;
  logic             wrapped;
  logic             overflow;
  logic             in_hs;
  logic             a_fin;
  logic             b_fin;

  assign in_word            = '{value: bus.s_axis_tdata, tag: idx};
  assign bus.s_axis_tready  = aresetn && (state != PAIR);
  assign in_hs              = bus.s_axis_tvalid && bus.s_axis_tready;

  assign bus.m_axis_a_tvalid = (state == PAIR) && !a_done;
  assign bus.m_axis_b_tvalid = (state == PAIR) && !b_done;
  assign bus.m_axis_a_tdata  = a_word;
  assign bus.m_axis_b_tdata  = b_word;
  assign bus.m_axis_a_tlast  = pair_last;
  assign bus.m_axis_b_tlast  = pair_last;
  assign bus.tag_overflow    = overflow;

  assign a_fin = a_done || (bus.m_axis_a_tvalid && bus.m_axis_a_tready);
  assign b_fin = b_done || (bus.m_axis_b_tvalid && bus.m_axis_b_tready);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= EMPTY;
      a_word    <= '0;
      b_word    <= '0;
      idx       <= '0;
      pair_last <= 1'b0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      wrapped   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // wrapped marks that tag 15 was issued; any later element overflows the tag space
      if (in_hs) begin
        idx <= idx + TAG_W'(1);
        if (idx == TAG_MAX) wrapped <= 1'b1;
        if (wrapped) overflow <= 1'b1;
      end
      case (state)
        EMPTY: begin
          if (in_hs) begin
            a_word <= in_word;
            if (bus.s_axis_tlast) begin
              b_word    <= in_word;
              pair_last <= 1'b1;
              state     <= PAIR;
            end else begin
              state <= HELD;
            end
          end
        end
        HELD: begin
          if (in_hs) begin
            b_word    <= in_word;
            pair_last <= bus.s_axis_tlast;
            state     <= PAIR;
          end
        end
        PAIR: begin
          a_done <= a_fin;
          b_done <= b_fin;
          if (a_fin && b_fin) begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            state  <= EMPTY;
            if (pair_last) begin
              idx      <= '0;
              wrapped  <= 1'b0;
              overflow <= 1'b0;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_float_argmin_feeder.sv
// Bench for float_argmin_feeder: directed scenarios plus random packets and readies, checked against
// a packet-level model that pairs elements, tags them by position mod 16 and duplicates odd tails.
module tb_float_argmin_feeder;

  localparam int SIZE = 32;

  logic aclk;
  logic aresetn;
  int   checks;
  int   failures;
  logic [SIZE-1:0] vals [64];

  float_argmin_feeder_if #(.SIZE(SIZE)) bus ();

  float_argmin_feeder #(.SIZE(SIZE)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic idle_inputs();
    bus.s_axis_tvalid   = 1'b0;
    bus.s_axis_tdata    = '0;
    bus.s_axis_tlast    = 1'b0;
    bus.m_axis_a_tready = 1'b0;
    bus.m_axis_b_tready = 1'b0;
  endtask

  // Streams vals[0..n-1] as one packet with random valid/ready densities and checks every cycle.
  task automatic run_stream(input int n, input int in_pct, input int a_pct, input int b_pct);
    logic [SIZE+4:0] exp_a [$];
    logic [SIZE+4:0] exp_b [$];
    logic [SIZE+3:0] hold_a, hold_b;
    logic [SIZE+3:0] wa, wb;
    int  np, sent, cnt, got_a, got_b, formed, in_pair, cycles;
    bit  pend, prev_any, stall_a, stall_b, a_hs, b_hs, lst;
    np = (n + 1) / 2;
    for (int k = 0; k < np; k++) begin
      wa  = {vals[2*k], 4'(2*k)};
      wb  = (2*k + 1 < n) ? {vals[2*k+1], 4'(2*k+1)} : wa;
      lst = (2*k + 2 >= n);
      exp_a.push_back({wa, lst});
      exp_b.push_back({wb, lst});
    end
    sent = 0; cnt = 0; got_a = 0; got_b = 0; formed = 0; in_pair = 0; cycles = 0;
    pend = 0; prev_any = 0; stall_a = 0; stall_b = 0; hold_a = '0; hold_b = '0;
    while ((got_a < np || got_b < np) && cycles < 3000) begin
      @(negedge aclk);
      cycles++;
      bus.s_axis_tvalid   = (sent < n) && ($urandom_range(99) < in_pct);
      bus.s_axis_tdata    = (sent < n) ? vals[sent] : '0;
      bus.s_axis_tlast    = (sent == n - 1);
      bus.m_axis_a_tready = ($urandom_range(99) < a_pct);
      bus.m_axis_b_tready = ($urandom_range(99) < b_pct);
      #1;
      checks++;
      if (bus.s_axis_tready !== !pend) begin
        failures++;
        $display("FAIL stream_tready cycle=%0d got=%b want=%b", cycles, bus.s_axis_tready, !pend);
      end
      checks++;
      if (bus.tag_overflow !== (cnt > 16)) begin
        failures++;
        $display("FAIL stream_overflow accepted=%0d got=%b want=%b", cnt, bus.tag_overflow, cnt > 16);
      end
      if (!prev_any && (bus.m_axis_a_tvalid || bus.m_axis_b_tvalid)) begin
        checks++;
        if (!(bus.m_axis_a_tvalid && bus.m_axis_b_tvalid)) begin
          failures++;
          $display("FAIL stream_joint_valid a=%b b=%b want both 1", bus.m_axis_a_tvalid, bus.m_axis_b_tvalid);
        end
      end
      if (stall_a) begin
        checks++;
        if (!bus.m_axis_a_tvalid || bus.m_axis_a_tdata !== hold_a) begin
          failures++;
          $display("FAIL stream_a_stable vld=%b got=%h want=%h", bus.m_axis_a_tvalid, bus.m_axis_a_tdata, hold_a);
        end
      end
      if (stall_b) begin
        checks++;
        if (!bus.m_axis_b_tvalid || bus.m_axis_b_tdata !== hold_b) begin
          failures++;
          $display("FAIL stream_b_stable vld=%b got=%h want=%h", bus.m_axis_b_tvalid, bus.m_axis_b_tdata, hold_b);
        end
      end
      a_hs = bus.m_axis_a_tvalid && bus.m_axis_a_tready;
      b_hs = bus.m_axis_b_tvalid && bus.m_axis_b_tready;
      if (a_hs) begin
        checks++;
        if (got_a >= np || {bus.m_axis_a_tdata, bus.m_axis_a_tlast} !== exp_a[got_a]) begin
          failures++;
          $display("FAIL stream_a_pair idx=%0d got=%h want=%h", got_a,
                   {bus.m_axis_a_tdata, bus.m_axis_a_tlast}, (got_a < np) ? exp_a[got_a] : '0);
        end
        got_a++;
      end
      if (b_hs) begin
        checks++;
        if (got_b >= np || {bus.m_axis_b_tdata, bus.m_axis_b_tlast} !== exp_b[got_b]) begin
          failures++;
          $display("FAIL stream_b_pair idx=%0d got=%h want=%h", got_b,
                   {bus.m_axis_b_tdata, bus.m_axis_b_tlast}, (got_b < np) ? exp_b[got_b] : '0);
        end
        got_b++;
      end
      stall_a  = bus.m_axis_a_tvalid && !bus.m_axis_a_tready;
      stall_b  = bus.m_axis_b_tvalid && !bus.m_axis_b_tready;
      hold_a   = bus.m_axis_a_tdata;
      hold_b   = bus.m_axis_b_tdata;
      prev_any = bus.m_axis_a_tvalid || bus.m_axis_b_tvalid;
      if (pend && got_a >= formed && got_b >= formed) begin
        pend = 0;
        prev_any = 0;
        if (formed == np) cnt = 0;
      end
      if (bus.s_axis_tvalid && bus.s_axis_tready) begin
        sent++;
        cnt++;
        in_pair++;
        if (in_pair == 2 || sent == n) begin
          pend = 1;
          formed++;
          in_pair = 0;
        end
      end
    end
    if (got_a < np || got_b < np) begin
      failures++;
      $display("FAIL stream_timeout got_a=%0d got_b=%0d want=%0d", got_a, got_b, np);
    end
    @(negedge aclk);
    idle_inputs();
    #1;
    checks++;
    if (bus.s_axis_tready !== 1'b1 || bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_b_tvalid !== 1'b0 ||
        bus.tag_overflow !== 1'b0) begin
      failures++;
      $display("FAIL stream_idle tready=%b a_vld=%b b_vld=%b ovf=%b want 1 0 0 0", bus.s_axis_tready,
               bus.m_axis_a_tvalid, bus.m_axis_b_tvalid, bus.tag_overflow);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (bus.s_axis_tready !== 1'b0 || bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_b_tvalid !== 1'b0 ||
        bus.m_axis_a_tdata !== '0 || bus.m_axis_b_tdata !== '0 || bus.m_axis_a_tlast !== 1'b0 ||
        bus.tag_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state tready=%b a_vld=%b b_vld=%b a=%h b=%h last=%b ovf=%b want all 0",
               bus.s_axis_tready, bus.m_axis_a_tvalid, bus.m_axis_b_tvalid, bus.m_axis_a_tdata,
               bus.m_axis_b_tdata, bus.m_axis_a_tlast, bus.tag_overflow);
    end
    aresetn = 1'b1;
    #1;
    checks++;
    if (bus.s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_tready got=%b want=1", bus.s_axis_tready);
    end
  endtask

  task automatic test_four_floats();
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h3F000000; vals[3] = 32'h40400000;
    run_stream(4, 100, 100, 100);
  endtask

  task automatic test_odd_pad();
    vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
    run_stream(3, 100, 100, 100);
    vals[0] = 32'h7; vals[1] = 32'h8;
    run_stream(2, 100, 100, 100);
  endtask

  task automatic test_staggered();
    logic [SIZE+3:0] held_b;
    int a_count;
    a_count = 0;
    @(negedge aclk);
    bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'hAAAA0001; bus.s_axis_tlast = 1'b0;
    @(negedge aclk);
    bus.s_axis_tdata = 32'hBBBB0002; bus.s_axis_tlast = 1'b1;
    @(negedge aclk);
    idle_inputs();
    bus.m_axis_a_tready = 1'b1;
    #1;
    checks++;
    if (bus.m_axis_a_tdata !== {32'hAAAA0001, 4'h0} || bus.m_axis_b_tdata !== {32'hBBBB0002, 4'h1} ||
        bus.m_axis_a_tlast !== 1'b1 || !bus.m_axis_a_tvalid || !bus.m_axis_b_tvalid) begin
      failures++;
      $display("FAIL stagger_pair a=%h b=%h last=%b vld=%b%b want aaaa00010 bbbb00021 1 11",
               bus.m_axis_a_tdata, bus.m_axis_b_tdata, bus.m_axis_a_tlast,
               bus.m_axis_a_tvalid, bus.m_axis_b_tvalid);
    end
    held_b = bus.m_axis_b_tdata;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        @(negedge aclk);
        #1;
      end
      if (bus.m_axis_a_tvalid && bus.m_axis_a_tready) a_count++;
      checks++;
      if (!bus.m_axis_b_tvalid || bus.m_axis_b_tdata !== held_b || bus.s_axis_tready !== 1'b0) begin
        failures++;
        $display("FAIL stagger_b_hold c=%0d b_vld=%b b=%h tready=%b want 1 %h 0", c,
                 bus.m_axis_b_tvalid, bus.m_axis_b_tdata, bus.s_axis_tready, held_b);
      end
    end
    checks++;
    if (a_count !== 1 || bus.m_axis_a_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL stagger_a_once count=%0d a_vld=%b want 1 0", a_count, bus.m_axis_a_tvalid);
    end
    @(negedge aclk);
    bus.m_axis_b_tready = 1'b1;
    #1;
    checks++;
    if (!bus.m_axis_b_tvalid || bus.s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL stagger_b_release b_vld=%b tready=%b want 1 0", bus.m_axis_b_tvalid, bus.s_axis_tready);
    end
    @(negedge aclk);
    idle_inputs();
    #1;
    checks++;
    if (bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_b_tvalid !== 1'b0 || bus.s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL stagger_retire a_vld=%b b_vld=%b tready=%b want 0 0 1",
               bus.m_axis_a_tvalid, bus.m_axis_b_tvalid, bus.s_axis_tready);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 18; i++) vals[i] = 32'h1000 + i;
    run_stream(18, 100, 100, 100);
    for (int i = 0; i < 19; i++) vals[i] = $urandom;
    run_stream(19, 70, 60, 60);
  endtask

  task automatic test_reset_mid_pair();
    @(negedge aclk);
    bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'hDEAD0000; bus.s_axis_tlast = 1'b0;
    @(negedge aclk);
    bus.s_axis_tdata = 32'hDEAD0001;
    @(negedge aclk);
    idle_inputs();
    bus.m_axis_a_tready = 1'b1;
    @(negedge aclk);
    bus.m_axis_a_tready = 1'b0;
    aresetn = 1'b0;
    #1;
    checks++;
    if (bus.s_axis_tready !== 1'b0 || bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_b_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL midreset_before tready=%b a_vld=%b b_vld=%b want 0 0 1",
               bus.s_axis_tready, bus.m_axis_a_tvalid, bus.m_axis_b_tvalid);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    checks++;
    if (bus.s_axis_tready !== 1'b1 || bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_b_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_after tready=%b a_vld=%b b_vld=%b want 1 0 0",
               bus.s_axis_tready, bus.m_axis_a_tvalid, bus.m_axis_b_tvalid);
    end
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    run_stream(3, 100, 100, 100);
  endtask

  task automatic test_back_to_back();
    int sent, pairs;
    logic [SIZE+3:0] wa;
    sent = 0; pairs = 0;
    for (int i = 0; i < 6; i++) vals[i] = $urandom;
    bus.m_axis_a_tready = 1'b1;
    bus.m_axis_b_tready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge aclk);
      bus.s_axis_tvalid = (sent < 6);
      bus.s_axis_tdata  = (sent < 6) ? vals[sent] : '0;
      bus.s_axis_tlast  = (sent == 5);
      #1;
      checks++;
      if (bus.s_axis_tready !== (c % 3 != 2)) begin
        failures++;
        $display("FAIL b2b_tready cycle=%0d got=%b want=%b", c, bus.s_axis_tready, c % 3 != 2);
      end
      if (bus.m_axis_a_tvalid && bus.m_axis_b_tvalid) begin
        wa = {vals[2*pairs], 4'(2*pairs)};
        checks++;
        if (bus.m_axis_a_tdata !== wa) begin
          failures++;
          $display("FAIL b2b_a_data pair=%0d got=%h want=%h", pairs, bus.m_axis_a_tdata, wa);
        end
        pairs++;
      end
      if (bus.s_axis_tvalid && bus.s_axis_tready) sent++;
    end
    checks++;
    if (pairs !== 3) begin
      failures++;
      $display("FAIL b2b_pair_count got=%0d want=3", pairs);
    end
    @(negedge aclk);
    idle_inputs();
  endtask

  task automatic test_random();
    int n;
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 22);
      for (int i = 0; i < n; i++) vals[i] = $urandom;
      run_stream(n, $urandom_range(40, 100), $urandom_range(30, 100), $urandom_range(30, 100));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    aresetn  = 1'b0;
    test_reset();
    test_four_floats();
    test_odd_pad();
    test_staggered();
    test_overflow();
    test_reset_mid_pair();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
